control_sequencer: RTL and testbench
====================================

# control_sequencer

Control unit for the 4-bit microprocessor. A three-state sequencer (FETCH, EXEC, ADDR) drives the program counter, the fetch register, the accumulator, the ALU function select, the operand/ALU/input tri-state buffers, RAM chip-select/write-enable and the output latch. It holds the carry/zero flag register and resolves conditional jumps from a two-byte instruction format (opcode/hi-nibble byte plus low-address byte). It sits between the fetch register (instr/oprnd) and every enable/select pin of the datapath.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces idle state immediately
- hold  input  1  when 1 in FETCH, sequencer stalls (no strobes)
- instr  input  4  opcode from fetch register, stable from EXEC until next FETCH edge
- oprnd  input  4  operand nibble from fetch register
- rom_data  input  8  current ROM byte at PC
- carry_in, zero_in  input  1 each  ALU carry/zero outputs
- phase  output  1  0 in FETCH, 1 in EXEC/ADDR
- fetch_en  output  1  fetch register load strobe
- inc_pc, load_pc  output  1 each  PC increment / parallel load
- pc_target  output  12  {oprnd, addr_lo}, PC load value
- ld_accu, ld_flags  output  1 each  accumulator load / internal flag update
- alu_f  output  3  000 pass A, 001 A−B, 010 pass B, 011 A+B, 100 NAND
- oe_oprnd, oe_alu, oe_in  output  1 each  bus buffer enables
- cs_ram, we_ram, ld_out  output  1 each  RAM select/write, output-port latch
- carry_flag, zero_flag  output  1 each  registered flags

## Operation
- FETCH: fetch_en=1, inc_pc=1 → EXEC. If hold=1: all strobes 0, stay in FETCH.
- EXEC, non-jump opcodes (→ FETCH): every unlisted control is 0.
  - 2 CMPI: oe_oprnd, alu_f=001, ld_flags
  - 3 CMPM: cs_ram, alu_f=001, ld_flags
  - 4 LIT: oe_oprnd, alu_f=010, ld_accu
  - 5 IN: oe_in, alu_f=010, ld_accu
  - 6 LD: cs_ram, alu_f=010, ld_accu
  - 7 ST: alu_f=000, oe_alu, cs_ram, we_ram
  - A ADDI / B ADDM: oe_oprnd / cs_ram, alu_f=011, ld_accu, ld_flags
  - D OUT: alu_f=000, oe_alu, ld_out
  - E NANDI / F NANDM: oe_oprnd / cs_ram, alu_f=100, ld_accu, ld_flags
- EXEC, jump opcodes 0 JC, 1 JNC, 8 JZ, 9 JNZ, C JMP: inc_pc=1, addr_lo<=rom_data → ADDR.
- ADDR: condition from registered flags (JC: C=1, JNC: C=0, JZ: Z=1, JNZ: Z=0, JMP: always). Taken: load_pc=1, pc_target={oprnd, addr_lo}. Not taken: no strobe. → FETCH.
- Flags: on rising edge with ld_flags=1, carry_flag<=carry_in, zero_flag<=zero_in; otherwise held. A flag update and a jump never coincide (flags read only in ADDR).
- load_pc and inc_pc never both 1. we_ram only with cs_ram; oe_alu never with oe_oprnd or oe_in.
- Controls are combinational from state, instr and flags; no glitch requirement beyond settling before the edge.

## Timing
- Reset (asserted, or asynchronously mid-instruction): state=FETCH, addr_lo=0, flags=0; while reset=1 every output is 0 (phase=0, pc_target=0). First fetch_en on the first edge after release.
- Non-jump instruction: 2 cycles. Jump (taken or not): 3 cycles. PC advances 1 per byte consumed.
- hold sampled only in FETCH; hold asserted during EXEC/ADDR has no effect until the next FETCH.
- pc_target valid only in ADDR; otherwise {oprnd, addr_lo} still driven.
- Opcode/flags wrap: none; alu_f encodings above are exhaustive, 101–111 never driven.

## Test plan
- Reset then release, instr=4 oprnd=5: cycle 1 fetch_en=inc_pc=1, cycle 2 oe_oprnd=1 alu_f=010 ld_accu=1, cycle 3 FETCH again.
- ADDI with carry_in=1 zero_in=0 in EXEC → after edge carry_flag=1 zero_flag=0; following CMPI with zero_in=1 → zero_flag=1, carry_flag=carry_in.
- JC, oprnd=3, rom_data=0x4A in EXEC, carry_flag=1: ADDR asserts load_pc=1, pc_target=0x34A; with carry_flag=0 no load_pc, 3 cycles total.
- JMP, oprnd=F, rom_data=0xFF: pc_target=0xFFF, load_pc=1 regardless of flags; JNZ with zero_flag=1 not taken.
- hold=1 for 4 cycles in FETCH → no strobes, phase=0; release → normal fetch. hold raised in EXEC → EXEC completes.
- reset pulsed in EXEC of ST: we_ram/cs_ram drop immediately, flags=0, next cycle after release is FETCH.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bundle between the 4-bit CPU sequencer and its datapath.
// The sequencer side is the master; the datapath side is the slave.
interface control_sequencer_if;
    logic        hold;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [7:0]  rom_data;
    logic        carry_in;
    logic        zero_in;
    logic        phase;
    logic        fetch_en;
    logic        inc_pc;
    logic        load_pc;
    logic [11:0] pc_target;
    logic        ld_accu;
    logic        ld_flags;
    logic [2:0]  alu_f;
    logic        oe_oprnd;
    logic        oe_alu;
    logic        oe_in;
    logic        cs_ram;
    logic        we_ram;
    logic        ld_out;
    logic        carry_flag;
    logic        zero_flag;

    modport master (
        input  hold, instr, oprnd, rom_data, carry_in, zero_in,
        output phase, fetch_en, inc_pc, load_pc, pc_target,
        output ld_accu, ld_flags, alu_f,
        output oe_oprnd, oe_alu, oe_in,
        output cs_ram, we_ram, ld_out,
        output carry_flag, zero_flag
    );

    modport slave (
        output hold, instr, oprnd, rom_data, carry_in, zero_in,
        input  phase, fetch_en, inc_pc, load_pc, pc_target,
        input  ld_accu, ld_flags, alu_f,
        input  oe_oprnd, oe_alu, oe_in,
        input  cs_ram, we_ram, ld_out,
        input  carry_flag, zero_flag
    );
endinterface

// File: rtl/control_sequencer.sv
// FETCH/EXEC/ADDR sequencer for the 4-bit CPU: datapath strobes,
// flag register and two-byte conditional jump resolution.
module control_sequencer (
    input logic                 clk,
    input logic                 reset,
    control_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_ADDR  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_addr_lo;
    logic       r_carry;
    logic       r_zero;

    logic       w_jump;
    logic       w_taken;
    logic       w_phase;
    logic       w_fetch_en;
    logic       w_inc_pc;
    logic       w_load_pc;
    logic       w_ld_accu;
    logic       w_ld_flags;
    logic [2:0] w_alu_f;
    logic       w_oe_oprnd;
    logic       w_oe_alu;
    logic       w_oe_in;
    logic       w_cs_ram;
    logic       w_we_ram;
    logic       w_ld_out;

    assign w_jump = (bus.instr == 4'h0) || (bus.instr == 4'h1) ||
                    (bus.instr == 4'h8) || (bus.instr == 4'h9) ||
                    (bus.instr == 4'hC);

    // Jump condition uses only the registered flags.
    always_comb begin
        w_taken = 1'b0;
        case (bus.instr)
            4'h0:    w_taken = r_carry;
            4'h1:    w_taken = ~r_carry;
            4'h8:    w_taken = r_zero;
            4'h9:    w_taken = ~r_zero;
            4'hC:    w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_phase    = 1'b0;
        w_fetch_en = 1'b0;
        w_inc_pc   = 1'b0;
        w_load_pc  = 1'b0;
        w_ld_accu  = 1'b0;
        w_ld_flags = 1'b0;
        w_alu_f    = 3'b000;
        w_oe_oprnd = 1'b0;
        w_oe_alu   = 1'b0;
        w_oe_in    = 1'b0;
        w_cs_ram   = 1'b0;
        w_we_ram   = 1'b0;
        w_ld_out   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (!bus.hold) begin
                    w_fetch_en = 1'b1;
                    w_inc_pc   = 1'b1;
                    w_next     = S_EXEC;
                end
            end
            S_EXEC: begin
                w_phase = 1'b1;
                w_next  = S_FETCH;
                if (w_jump) begin
                    w_inc_pc = 1'b1;
                    w_next   = S_ADDR;
                end else begin
                    case (bus.instr)
                        4'h2: begin
                            w_oe_oprnd = 1'b1;
                            w_alu_f    = 3'b001;
                            w_ld_flags = 1'b1;
                        end
                        4'h3: begin
                            w_cs_ram   = 1'b1;
                            w_alu_f    = 3'b001;
                            w_ld_flags = 1'b1;
                        end
                        4'h4: begin
                            w_oe_oprnd = 1'b1;
                            w_alu_f    = 3'b010;
                            w_ld_accu  = 1'b1;
                        end
                        4'h5: begin
                            w_oe_in   = 1'b1;
                            w_alu_f   = 3'b010;
                            w_ld_accu = 1'b1;
                        end
                        4'h6: begin
                            w_cs_ram  = 1'b1;
                            w_alu_f   = 3'b010;
                            w_ld_accu = 1'b1;
                        end
                        4'h7: begin
                            w_oe_alu = 1'b1;
                            w_cs_ram = 1'b1;
                            w_we_ram = 1'b1;
                        end
                        4'hA, 4'hB: begin
                            w_oe_oprnd = ~bus.instr[0];
                            w_cs_ram   = bus.instr[0];
                            w_alu_f    = 3'b011;
                            w_ld_accu  = 1'b1;
                            w_ld_flags = 1'b1;
                        end
                        4'hD: begin
                            w_oe_alu = 1'b1;
                            w_ld_out = 1'b1;
                        end
                        4'hE, 4'hF: begin
                            w_oe_oprnd = ~bus.instr[0];
                            w_cs_ram   = bus.instr[0];
                            w_alu_f    = 3'b100;
                            w_ld_accu  = 1'b1;
                            w_ld_flags = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_ADDR: begin
                w_phase   = 1'b1;
                w_load_pc = w_taken;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_addr_lo <= 8'h00;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC && w_jump)
                r_addr_lo <= bus.rom_data;
            if (w_ld_flags) begin
                r_carry <= bus.carry_in;
                r_zero  <= bus.zero_in;
            end
        end
    end

    // Outputs are forced quiet for as long as reset is held.
    assign bus.phase      = w_phase    & ~reset;
    assign bus.fetch_en   = w_fetch_en & ~reset;
    assign bus.inc_pc     = w_inc_pc   & ~reset;
    assign bus.load_pc    = w_load_pc  & ~reset;
    assign bus.ld_accu    = w_ld_accu  & ~reset;
    assign bus.ld_flags   = w_ld_flags & ~reset;
    assign bus.alu_f      = reset ? 3'b000 : w_alu_f;
    assign bus.oe_oprnd   = w_oe_oprnd & ~reset;
    assign bus.oe_alu     = w_oe_alu   & ~reset;
    assign bus.oe_in      = w_oe_in    & ~reset;
    assign bus.cs_ram     = w_cs_ram   & ~reset;
    assign bus.we_ram     = w_we_ram   & ~reset;
    assign bus.ld_out     = w_ld_out   & ~reset;
    assign bus.pc_target  = reset ? 12'h000 : {bus.oprnd, r_addr_lo};
    assign bus.carry_flag = r_carry;
    assign bus.zero_flag  = r_zero;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, reset corner case,
// then random instruction streams against an instruction-level model.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic reset;

    control_sequencer_if bus();

    control_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        logic        hold;
        logic [3:0]  instr;
        logic [3:0]  oprnd;
        logic [7:0]  rom;
        logic        cin;
        logic        zin;
        logic [16:0] ctl;
        logic [7:0]  alo;
    } vec_t;

    vec_t tv[$];

    function automatic logic [16:0] mk(
        input logic ph, fe, ip, lp, la, lf,
        input logic [2:0] f,
        input logic oo, oa, oi, cs, we, lo, cf, zf);
        mk = {ph, fe, ip, lp, la, lf, f, oo, oa, oi, cs, we, lo, cf, zf};
    endfunction

    function automatic logic [16:0] fch(input logic cf, zf);
        fch = mk(0,1,1,0,0,0,3'b000,0,0,0,0,0,0,cf,zf);
    endfunction
    function automatic logic [16:0] hld(input logic cf, zf);
        hld = mk(0,0,0,0,0,0,3'b000,0,0,0,0,0,0,cf,zf);
    endfunction
    function automatic logic [16:0] jex(input logic cf, zf);
        jex = mk(1,0,1,0,0,0,3'b000,0,0,0,0,0,0,cf,zf);
    endfunction
    function automatic logic [16:0] jld(input logic cf, zf);
        jld = mk(1,0,0,1,0,0,3'b000,0,0,0,0,0,0,cf,zf);
    endfunction
    function automatic logic [16:0] nop(input logic cf, zf);
        nop = mk(1,0,0,0,0,0,3'b000,0,0,0,0,0,0,cf,zf);
    endfunction

    function automatic vec_t rw(
        input logic h, input logic [3:0] i, o, input logic [7:0] r,
        input logic ci, zi, input logic [16:0] c, input logic [7:0] a);
        rw.hold  = h;
        rw.instr = i;
        rw.oprnd = o;
        rw.rom   = r;
        rw.cin   = ci;
        rw.zin   = zi;
        rw.ctl   = c;
        rw.alo   = a;
    endfunction

    function automatic logic [28:0] obs();
        obs = {bus.phase, bus.fetch_en, bus.inc_pc, bus.load_pc,
               bus.ld_accu, bus.ld_flags, bus.alu_f,
               bus.oe_oprnd, bus.oe_alu, bus.oe_in,
               bus.cs_ram, bus.we_ram, bus.ld_out,
               bus.carry_flag, bus.zero_flag, bus.pc_target};
    endfunction

    task automatic check(input string nm, input logic [28:0] act, exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic [3:0] i, o,
                         input logic [7:0] r, input logic ci, zi);
        bus.hold     = h;
        bus.instr    = i;
        bus.oprnd    = o;
        bus.rom_data = r;
        bus.carry_in = ci;
        bus.zero_in  = zi;
    endtask

    // Instruction-level reference: cycle index within the instruction.
    int         m_step;
    logic       m_c, m_z;
    logic [7:0] m_alo;

    function automatic logic is_jmp(input logic [3:0] op);
        is_jmp = op inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC};
    endfunction

    function automatic logic sets_flags(input logic [3:0] op);
        sets_flags = op inside {4'h2, 4'h3, 4'hA, 4'hB, 4'hE, 4'hF};
    endfunction

    function automatic logic m_taken(input logic [3:0] op, input logic c, z);
        case (op)
            4'h0:    m_taken = c;
            4'h1:    m_taken = !c;
            4'h8:    m_taken = z;
            4'h9:    m_taken = !z;
            4'hC:    m_taken = 1'b1;
            default: m_taken = 1'b0;
        endcase
    endfunction

    function automatic logic [16:0] m_exec(input logic [3:0] op,
                                           input logic c, z);
        logic [2:0] f;
        logic src_imm, src_ram, src_in, to_acc, store, out;
        f = 3'b000; src_imm = 0; src_ram = 0; src_in = 0;
        to_acc = 0; store = 0; out = 0;
        case (op)
            4'h2: begin src_imm = 1; f = 3'b001; end
            4'h3: begin src_ram = 1; f = 3'b001; end
            4'h4: begin src_imm = 1; f = 3'b010; to_acc = 1; end
            4'h5: begin src_in  = 1; f = 3'b010; to_acc = 1; end
            4'h6: begin src_ram = 1; f = 3'b010; to_acc = 1; end
            4'h7: store = 1;
            4'hA: begin src_imm = 1; f = 3'b011; to_acc = 1; end
            4'hB: begin src_ram = 1; f = 3'b011; to_acc = 1; end
            4'hD: out = 1;
            4'hE: begin src_imm = 1; f = 3'b100; to_acc = 1; end
            4'hF: begin src_ram = 1; f = 3'b100; to_acc = 1; end
            default: ;
        endcase
        m_exec = mk(1, 0, 0, 0, to_acc, sets_flags(op), f,
                    src_imm, store | out, src_in,
                    src_ram | store, store, out, c, z);
    endfunction

    function automatic logic [16:0] m_expect(input logic h,
                                             input logic [3:0] op);
        if (m_step == 0)
            m_expect = h ? hld(m_c, m_z) : fch(m_c, m_z);
        else if (m_step == 1)
            m_expect = is_jmp(op) ? jex(m_c, m_z) : m_exec(op, m_c, m_z);
        else
            m_expect = m_taken(op, m_c, m_z) ? jld(m_c, m_z)
                                              : nop(m_c, m_z);
    endfunction

    task automatic m_update(input logic h, input logic [3:0] op,
                            input logic [7:0] r, input logic ci, zi);
        if (m_step == 0) begin
            if (!h) m_step = 1;
        end else if (m_step == 1) begin
            if (is_jmp(op)) begin
                m_alo  = r;
                m_step = 2;
            end else begin
                if (sets_flags(op)) begin
                    m_c = ci;
                    m_z = zi;
                end
                m_step = 0;
            end
        end else begin
            m_step = 0;
        end
    endtask

    logic       r_h, r_ci, r_zi;
    logic [3:0] r_op, r_opr;
    logic [7:0] r_rom;

    initial begin
        tv.push_back(rw(0,4'h4,4'h5,8'h00,0,0, fch(0,0), 8'h00));
        tv.push_back(rw(0,4'h4,4'h5,8'h00,0,0,
            mk(1,0,0,0,1,0,3'b010,1,0,0,0,0,0,0,0), 8'h00));
        tv.push_back(rw(0,4'hA,4'h1,8'h00,0,0, fch(0,0), 8'h00));
        tv.push_back(rw(0,4'hA,4'h1,8'h00,1,0,
            mk(1,0,0,0,1,1,3'b011,1,0,0,0,0,0,0,0), 8'h00));
        tv.push_back(rw(0,4'h2,4'h7,8'h00,0,0, fch(1,0), 8'h00));
        tv.push_back(rw(0,4'h2,4'h7,8'h00,0,1,
            mk(1,0,0,0,0,1,3'b001,1,0,0,0,0,0,1,0), 8'h00));
        tv.push_back(rw(0,4'hB,4'h0,8'h00,0,0, fch(0,1), 8'h00));
        tv.push_back(rw(0,4'hB,4'h0,8'h00,1,0,
            mk(1,0,0,0,1,1,3'b011,0,0,0,1,0,0,0,1), 8'h00));
        tv.push_back(rw(0,4'h0,4'h3,8'h4A,0,0, fch(1,0), 8'h00));
        tv.push_back(rw(0,4'h0,4'h3,8'h4A,0,0, jex(1,0), 8'h00));
        tv.push_back(rw(0,4'h0,4'h3,8'h00,0,0, jld(1,0), 8'h4A));
        tv.push_back(rw(0,4'h2,4'h0,8'h00,0,0, fch(1,0), 8'h4A));
        tv.push_back(rw(0,4'h2,4'h0,8'h00,0,1,
            mk(1,0,0,0,0,1,3'b001,1,0,0,0,0,0,1,0), 8'h4A));
        tv.push_back(rw(0,4'h0,4'h3,8'h00,0,0, fch(0,1), 8'h4A));
        tv.push_back(rw(0,4'h0,4'h3,8'h12,0,0, jex(0,1), 8'h4A));
        tv.push_back(rw(0,4'h0,4'h3,8'h00,0,0, nop(0,1), 8'h12));
        tv.push_back(rw(0,4'hC,4'hF,8'h00,0,0, fch(0,1), 8'h12));
        tv.push_back(rw(0,4'hC,4'hF,8'hFF,0,0, jex(0,1), 8'h12));
        tv.push_back(rw(0,4'hC,4'hF,8'h00,0,0, jld(0,1), 8'hFF));
        tv.push_back(rw(0,4'h9,4'hF,8'h00,0,0, fch(0,1), 8'hFF));
        tv.push_back(rw(0,4'h9,4'hF,8'h00,0,0, jex(0,1), 8'hFF));
        tv.push_back(rw(0,4'h9,4'hF,8'h00,0,0, nop(0,1), 8'h00));
        for (int k = 0; k < 4; k++)
            tv.push_back(rw(1,4'h7,4'h0,8'h00,0,0, hld(0,1), 8'h00));
        tv.push_back(rw(0,4'h7,4'h0,8'h00,0,0, fch(0,1), 8'h00));
        tv.push_back(rw(1,4'h7,4'h0,8'h00,0,0,
            mk(1,0,0,0,0,0,3'b000,0,1,0,1,1,0,0,1), 8'h00));
        tv.push_back(rw(0,4'hD,4'h0,8'h00,0,0, fch(0,1), 8'h00));
        tv.push_back(rw(0,4'hD,4'h0,8'h00,0,0,
            mk(1,0,0,0,0,0,3'b000,0,1,0,0,0,1,0,1), 8'h00));
        tv.push_back(rw(0,4'h5,4'h0,8'h00,0,0, fch(0,1), 8'h00));
        tv.push_back(rw(0,4'h5,4'h0,8'h00,0,0,
            mk(1,0,0,0,1,0,3'b010,0,0,1,0,0,0,0,1), 8'h00));
        tv.push_back(rw(0,4'h6,4'h0,8'h00,0,0, fch(0,1), 8'h00));
        tv.push_back(rw(0,4'h6,4'h0,8'h00,0,0,
            mk(1,0,0,0,1,0,3'b010,0,0,0,1,0,0,0,1), 8'h00));
        tv.push_back(rw(0,4'hE,4'h2,8'h00,0,0, fch(0,1), 8'h00));
        tv.push_back(rw(0,4'hE,4'h2,8'h00,1,1,
            mk(1,0,0,0,1,1,3'b100,1,0,0,0,0,0,0,1), 8'h00));
        tv.push_back(rw(0,4'hF,4'h2,8'h00,0,0, fch(1,1), 8'h00));
        tv.push_back(rw(0,4'hF,4'h2,8'h00,0,0,
            mk(1,0,0,0,1,1,3'b100,0,0,0,1,0,0,1,1), 8'h00));
        tv.push_back(rw(0,4'h3,4'h2,8'h00,0,0, fch(0,0), 8'h00));
        tv.push_back(rw(0,4'h3,4'h2,8'h00,1,0,
            mk(1,0,0,0,0,1,3'b001,0,0,0,1,0,0,0,0), 8'h00));
        tv.push_back(rw(0,4'h1,4'h2,8'h00,0,0, fch(1,0), 8'h00));
        tv.push_back(rw(0,4'h1,4'h2,8'h33,0,0, jex(1,0), 8'h00));
        tv.push_back(rw(0,4'h1,4'h2,8'h00,0,0, nop(1,0), 8'h33));
        tv.push_back(rw(0,4'h8,4'h4,8'h00,0,0, fch(1,0), 8'h33));
        tv.push_back(rw(0,4'h8,4'h4,8'h55,0,0, jex(1,0), 8'h33));
        tv.push_back(rw(0,4'h8,4'h4,8'h00,0,0, nop(1,0), 8'h55));

        reset = 1'b1;
        drive(0, 4'h4, 4'h5, 8'hA5, 1, 1);
        @(negedge clk);
        #1 check("reset_idle", obs(), 29'h0);
        @(negedge clk);
        #1 check("reset_idle2", obs(), 29'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].hold, tv[k].instr, tv[k].oprnd,
                  tv[k].rom, tv[k].cin, tv[k].zin);
            #1 check($sformatf("vec%0d", k), obs(),
                     {tv[k].ctl, tv[k].oprnd, tv[k].alo});
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a store.
        drive(0, 4'h7, 4'h2, 8'h00, 0, 0);
        #1 check("st_fetch", obs(), {fch(1,0), 4'h2, 8'h55});
        @(negedge clk);
        #1 check("st_exec", obs(),
            {mk(1,0,0,0,0,0,3'b000,0,1,0,1,1,0,1,0), 4'h2, 8'h55});
        reset = 1'b1;
        #1 check("rst_async", obs(), 29'h0);
        @(negedge clk);
        #1 check("rst_held", obs(), 29'h0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_release", obs(), {fch(0,0), 4'h2, 8'h00});
        @(negedge clk);
        #1 check("rst_exec", obs(),
            {mk(1,0,0,0,0,0,3'b000,0,1,0,1,1,0,0,0), 4'h2, 8'h00});
        @(negedge clk);

        m_step = 0;
        m_c    = 1'b0;
        m_z    = 1'b0;
        m_alo  = 8'h00;
        r_op   = 4'h0;
        r_opr  = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            if (m_step == 0) begin
                r_op  = 4'($urandom_range(0, 15));
                r_opr = 4'($urandom_range(0, 15));
            end
            r_h   = ($urandom_range(0, 4) == 0);
            r_rom = 8'($urandom_range(0, 255));
            r_ci  = 1'($urandom_range(0, 1));
            r_zi  = 1'($urandom_range(0, 1));
            drive(r_h, r_op, r_opr, r_rom, r_ci, r_zi);
            #1 check($sformatf("rand%0d", n), obs(),
                     {m_expect(r_h, r_op), r_opr, m_alo});
            @(posedge clk);
            m_update(r_h, r_op, r_rom, r_ci, r_zi);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule
